// File: rtl/h_write_ctrl_if.sv
// H buffer write-side bundle: coefficient input stream plus the H storage write port.
// Latency: none (wires only).
// Backpressure: in_ready is driven by the controller (slave) back to the stream source (master).
interface h_write_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 2
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;

    // Stream source and H buffer observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_row, wr_col, wr_data
    );

    // Write controller side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_row, wr_col, wr_data
    );
endinterface

// File: rtl/h_write_ctrl.sv
// SOML H buffer write controller: column-fastest fill, load_h pulse, hold during read sweep.
// Latency: write strobe/address/data 1 cycle after handshake; load_h in the cycle of the last write.
// Backpressure: in_ready low in LOAD/HOLD (H_PINGPONG_EN: low only in LOAD or when next frame is parked).
module h_write_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ROWS     = 4,
    parameter int COLS     = 2,
    parameter int READ_LEN = 128
) (
    input  logic         clk,
    input  logic         rst,
    h_write_ctrl_if.slave bus,
    input  logic         flush,
    output logic         load_h,
    output logic         busy,
    output logic [7:0]   frame_cnt
`ifdef H_PINGPONG_EN
    ,
    output logic         wr_bank,
    output logic         rd_bank
`endif
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int IDX_W  = ROW_W + COL_W;
    localparam int HOLD_W = $clog2(READ_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ROWS * COLS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_LEN - 1);
`ifdef H_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        frame_q, frame_d;
    logic              pend_q, pend_d;   // next frame fully written, waiting for the sweep to end
    logic              wr_en_q, wr_en_d;
    logic [ROW_W-1:0]  wr_row_q, wr_row_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic in_rdy;
    logic take;
    logic last_word;
    logic flush_eff;
    logic enter_load;

    // Ready is a function of state only; held low while reset is asserted.
    always_comb begin
        in_rdy = 1'b0;
        if (state_q == FILL)
            in_rdy = 1'b1;
        else if (PP && state_q == HOLD && !pend_q)
            in_rdy = 1'b1;
        if (rst)
            in_rdy = 1'b0;
    end

    assign take      = bus.in_valid && in_rdy && !flush;
    assign last_word = take && (idx_q == LAST_IDX);
    // In single-bank mode flush only acts while filling; with ping-pong it also aborts the frame
    // being filled in the spare bank during HOLD. LOAD is always committed.
    assign flush_eff = flush && ((state_q == FILL) || (PP && state_q == HOLD));

    // Next-state, fill index, hold counter and registered write port.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        frame_d    = frame_q;
        pend_d     = pend_q;
        wr_en_d    = take;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_data_d  = wr_data_q;
        enter_load = 1'b0;

        if (take) begin
            wr_row_d  = idx_q[IDX_W-1:COL_W];
            wr_col_d  = idx_q[COL_W-1:0];
            wr_data_d = bus.in_data;
            idx_d     = last_word ? '0 : idx_q + IDX_W'(1);
        end

        if (flush_eff) begin
            idx_d  = '0;
            pend_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (last_word)
                    state_d = LOAD;
            end
            LOAD: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    frame_d = frame_q + 8'd1;
                    state_d = (pend_q || last_word) ? LOAD : FILL;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (last_word)
                        pend_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (state_d == LOAD && state_q != LOAD) begin
            enter_load = 1'b1;
            pend_d     = 1'b0;
        end
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            hold_q    <= '0;
            frame_q   <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            frame_q   <= frame_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef H_PINGPONG_EN
    logic fill_bank_q;   // bank currently being filled
    logic wr_bank_q;     // bank of the write presented on the write port
    logic rd_bank_q;

    // Bank tracking: the reader takes the just-filled bank, the filler moves to the other one.
    // wr_bank is registered with each write so the final word of a frame, which lands in the
    // LOAD cycle, still targets the bank that was filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            if (take)
                wr_bank_q <= fill_bank_q;
            if (enter_load) begin
                rd_bank_q   <= fill_bank_q;
                fill_bank_q <= ~fill_bank_q;
            end
        end
    end

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
`endif

    assign bus.in_ready = in_rdy;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_row   = wr_row_q;
    assign bus.wr_col   = wr_col_q;
    assign bus.wr_data  = wr_data_q;
    assign load_h       = (state_q == LOAD);
    assign busy         = (state_q == LOAD) || (state_q == HOLD);
    assign frame_cnt    = frame_q;

endmodule
